// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data memory: access-size encodings, controller
// state encoding, wait-counter width and the alignment/fault rule.
// -----------------------------------------------------------------------------
package data_mem_pkg;

    // Wide enough for wait-state counts 0..15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DONE  = 2'b10,
        ST_CLEAR = 2'b11
    } state_e;

    // An access faults when it is misaligned for its size or uses the
    // reserved size encoding.
    function automatic logic access_fault(input size_e sz, input logic [1:0] lo);
        logic f;
        case (sz)
            SIZE_BYTE: f = 1'b0;
            SIZE_HALF: f = lo[0];
            SIZE_WORD: f = (lo != 2'b00);
            default:   f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// -----------------------------------------------------------------------------
// dm_lane
// Combinational byte-lane logic for the data memory.
//   size_i      : access size encoding (see size_e)
//   sign_ext_i  : sign-extend load result when 1
//   addr_lo_i   : byte offset inside the word
//   wdata_i     : store data, byte/half in the low bits
//   rd_word_i   : full word read from the array
//   fault_o     : misaligned or reserved-size access
//   be_o        : per-lane write enables (zero on fault)
//   wr_word_o   : store data replicated onto every candidate lane
//   load_o      : extended load value (zero on fault)
// -----------------------------------------------------------------------------
module dm_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rd_word_i,
    output logic        fault_o,
    output logic [3:0]  be_o,
    output logic [31:0] wr_word_o,
    output logic [31:0] load_o
);

    size_e       sz;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign sz = size_e'(size_i);

    always_comb begin
        fault_o   = access_fault(sz, addr_lo_i);
        be_o      = 4'b0000;
        wr_word_o = 32'd0;
        load_o    = 32'd0;
        byte_v    = rd_word_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

        case (sz)
            SIZE_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                // Replicating the data lets the byte enables pick the lane.
                wr_word_o = {4{wdata_i[7:0]}};
                load_o    = {{24{sign_ext_i & byte_v[7]}}, byte_v};
            end
            SIZE_HALF: begin
                be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wr_word_o = {2{wdata_i[15:0]}};
                load_o    = {{16{sign_ext_i & half_v[15]}}, half_v};
            end
            SIZE_WORD: begin
                be_o      = 4'b1111;
                wr_word_o = wdata_i;
                load_o    = rd_word_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase

        if (fault_o) begin
            be_o   = 4'b0000;
            load_o = 32'd0;
        end
    end

endmodule

// File: rtl/data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Byte-addressable little-endian data memory with a fixed number of wait
// states per access and byte/half/word loads and stores.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   req        : access request, sampled only while busy=0
//   we         : 1 = store, 0 = load
//   size       : 00 byte, 01 half, 10 word, 11 reserved
//   sign_ext   : sign-extend load result
//   addr       : byte address
//   wdata      : store data
//   rdata      : load result while ready=1, otherwise 0
//   ready      : one-cycle completion pulse
//   busy       : access in flight (accept through ready) or clearing
//   fault      : misaligned/reserved access, only while ready=1
// Optional macro DATA_MEM_CLEAR_EN: after reset, zero the whole array one
// word per cycle before accepting requests.
// -----------------------------------------------------------------------------
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              fault
);

    localparam int WORD_AW = ADDR_W - 2;
    localparam int DEPTH   = 1 << WORD_AW;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        (WAIT_CYCLES == 0) ? WAIT_CNT_W'(0) : WAIT_CNT_W'(WAIT_CYCLES - 1);
`ifdef DATA_MEM_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    sign_ext_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [31:0]             wdata_q;
    logic                    accept;

    logic                    lane_fault;
    logic [3:0]              lane_be;
    logic [31:0]             lane_wr_word;
    logic [31:0]             lane_load;
    logic [31:0]             rd_word;

    logic [3:0]              mem_wr_en;
    logic [WORD_AW-1:0]      mem_wr_idx;
    logic [31:0]             mem_wr_word;

    assign accept = (state_q == ST_IDLE) && req;

    // Control state and the access captured at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                we_q       <= we;
                size_q     <= size;
                sign_ext_q <= sign_ext;
                addr_q     <= addr;
                wdata_q    <= wdata;
            end
        end
    end

`ifdef DATA_MEM_CLEAR_EN
    logic [WORD_AW-1:0] clr_idx_q;
    logic               clr_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
        end
    end

    assign clr_last = (clr_idx_q == '1);
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wait_cnt_d = '0;
                    state_d    = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
            ST_CLEAR: begin
`ifdef DATA_MEM_CLEAR_EN
                if (clr_last) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == ST_DONE);
        busy  = (state_q != ST_IDLE);
        fault = ready & lane_fault;
        // lane_load is already zero for a faulted access.
        rdata = (ready && !we_q) ? lane_load : 32'd0;
    end

    // The write happens on the edge that ends the DONE cycle; gating with
    // reset keeps a reset coinciding with that edge from committing it.
    always_comb begin
        mem_wr_en   = 4'b0000;
        mem_wr_idx  = addr_q[ADDR_W-1:2];
        mem_wr_word = lane_wr_word;
        if (!reset) begin
            if ((state_q == ST_DONE) && we_q) begin
                mem_wr_en = lane_be;
            end
`ifdef DATA_MEM_CLEAR_EN
            if (state_q == ST_CLEAR) begin
                mem_wr_en   = 4'b1111;
                mem_wr_idx  = clr_idx_q;
                mem_wr_word = 32'd0;
            end
`endif
        end
    end

    dm_lane u_lane (
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rd_word_i  (rd_word),
        .fault_o    (lane_fault),
        .be_o       (lane_be),
        .wr_word_o  (lane_wr_word),
        .load_o     (lane_load)
    );

    // One byte-wide array per lane. The read is registered at acceptance,
    // which always follows any earlier store's write edge, so a load right
    // after a store sees the new data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (mem_wr_en[gi]) begin
                    mem[mem_wr_idx] <= mem_wr_word[8*gi +: 8];
                end
                if (accept && !reset) begin
                    rd_q <= mem[addr[ADDR_W-1:2]];
                end
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule
